mod_sequence_monitor: RTL and testbench
=======================================

# mod_sequence_monitor

Downstream checker for the free-running mod-N counter. It samples the counter's output every valid cycle and locks onto the expected sequence 0, 1, …, N-1, 0. Once locked it:
- pulses on every wrap,
- counts completed periods,
- flags any out-of-sequence value.

It sits between the counter and the status/debug logic, giving a registered health indication for the counting stage.

## Interface
- N, default 8: modulus of the monitored counter; legal values 0..N-1; N ≥ 2.
- WIDTH, default 4: counter output width; must satisfy 2^WIDTH ≥ N.
- LOCK_CNT, default 2: consecutive correct steps needed to lock; ≥ 1.
- PERIOD_W, default 16: width of the period counter.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  synchronous, active-high reset.
- cnt_in  in  WIDTH  counter value being monitored.
- cnt_valid  in  1  sample cnt_in this cycle; tie high for a free-running counter.
- err_clear  in  1  clears err_sticky.
- locked  out  1  sequence tracking established.
- wrap_pulse  out  1  one-cycle pulse per locked N-1→0 transition.
- period_count  out  PERIOD_W  number of wraps seen while locked; saturating.
- err_pulse  out  1  one-cycle pulse per sequence error while locked.
- err_sticky  out  1  latched error flag.

## Operation
- Internal state: prev value (WIDTH bits), prev_ok flag, good-step counter, FSM state ∈ {ACQUIRE, LOCKED}.
- Next expected value: exp = (prev == N-1) ? 0 : prev+1. Wrap is explicit; there is no modulo of the raw sum. Width is WIDTH bits with no overflow.
- A sample is "good" only if all of the following hold:
  - cnt_valid = 1,
  - prev_ok = 1,
  - cnt_in < N,
  - cnt_in == exp.
- Cycles with cnt_valid = 0 hold all state. They are neither good nor bad.
- ACQUIRE state:
  - A good sample increments the good-step counter.
  - Any other valid sample clears the good-step counter.
  - When the good-step counter reaches LOCK_CNT, the FSM moves to LOCKED.
  - No errors or wraps are reported in ACQUIRE.
- LOCKED state:
  - A good sample with prev == N-1 and cnt_in == 0 pulses wrap_pulse and increments period_count. period_count holds at all-ones.
  - A valid non-good sample (mismatch or cnt_in ≥ N) does all of the following:
    - pulses err_pulse,
    - sets err_sticky,
    - returns the FSM to ACQUIRE,
    - clears the good-step counter.
- On every valid sample: prev ← cnt_in, and prev_ok ← (cnt_in < N).
- err_sticky clears on err_clear. If err_clear and a new error occur in the same cycle, set wins.
- period_count is not cleared on loss of lock. Only rst clears it.

## Timing
- All outputs are registered. Every response appears on the cycle after the sampling edge of cnt_in.
- Lock timing: locked rises one cycle after the sample that completes the LOCK_CNT-th good step. A wrap in that same sample is not counted.
- Error timing: on the erroring sample, err_pulse = 1 and locked = 0 in the same following cycle.
- Reset (rst = 1 at a rising edge):
  - Values after reset: state = ACQUIRE, prev = 0, prev_ok = 0, good count = 0. All outputs are 0, including period_count and err_sticky.
  - This applies mid-operation too. The cnt_in value present during the reset cycle is ignored.
- First valid sample after reset: it only loads prev and can never be good.

## Structure
- Shared package `modcnt_pkg`:
  - FSM state enum {ACQUIRE, LOCKED},
  - default N/WIDTH constants shared with the counter.
- One sub-module `mod_next`: combinational exp = next value mod N, parameterised N and WIDTH. It is reusable by the counter itself.
- Everything else lives in a single clocked process plus next-state logic.

## Test plan
All scenarios use N=8, WIDTH=4, LOCK_CNT=2.
- Reset, then free-running counter 0..7 repeating, with cnt_valid = 1 → locked = 1 the cycle after sample 2; wrap_pulse one cycle after each 7→0; period_count = 1 after the first wrap and 3 after the third.
- While locked, inject 5 in place of 4 → err_pulse for one cycle, err_sticky = 1, locked = 0. Continue with 6,7,0 → locked returns one cycle after the 7 sample.
- While locked, inject 9 (out of range) → error as above. The next value 0 is not good because prev_ok = 0. Relock occurs after samples 0,1,2.
- While locked, hold cnt_valid = 0 for 3 cycles with cnt_in frozen, then resume the sequence → no err_pulse, and locked stays 1.
- err_clear in the same cycle as an error → err_sticky = 1. err_clear alone on a later cycle → err_sticky = 0.
- Assert rst mid-sequence while locked with period_count = 3 → all outputs 0 on the next cycle. With PERIOD_W = 2, five wraps → period_count saturates at 3.

Source files
------------

// File: rtl/mod_sequence_monitor_pkg.sv
// Shared definitions for the mod-N counter and its sequence monitor.
package modcnt_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam int unsigned N_DEFAULT     = 8;
    localparam int unsigned WIDTH_DEFAULT = 4;

endpackage

// File: rtl/mod_sequence_monitor_if.sv
// Sample/status bundle between the counter stage and the sequence monitor.
interface mod_sequence_monitor_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PERIOD_W = 16
);
    logic [WIDTH-1:0]    cnt_in;
    logic                cnt_valid;
    logic                err_clear;
    logic                locked;
    logic                wrap_pulse;
    logic [PERIOD_W-1:0] period_count;
    logic                err_pulse;
    logic                err_sticky;

    modport master (
        output cnt_in, cnt_valid, err_clear,
        input  locked, wrap_pulse, period_count, err_pulse, err_sticky
    );

    modport slave (
        input  cnt_in, cnt_valid, err_clear,
        output locked, wrap_pulse, period_count, err_pulse, err_sticky
    );
endinterface

// File: rtl/mod_sequence_monitor_next.sv
// Next value of a mod-N count with an explicit wrap at N-1.
module mod_next
    import modcnt_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = (cur == WIDTH'(N - 1)) ? '0 : cur + WIDTH'(1);
    end

endmodule

// File: rtl/mod_sequence_monitor.sv
// Locks onto a free-running 0..N-1 count, reporting wraps, completed periods
// and out-of-sequence samples with registered outputs.
module mod_sequence_monitor
    import modcnt_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_sequence_monitor_if.slave bus
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    state_t              state, state_nx;
    logic [WIDTH-1:0]    prev;
    logic [WIDTH-1:0]    exp_val;
    logic                prev_ok;
    logic [GW-1:0]       good_cnt, good_cnt_nx;
    logic                in_range;
    logic                good;
    logic                wrap_nx, err_nx;
    logic                wrap_q, err_q, sticky_q;
    logic [PERIOD_W-1:0] period_q;

    mod_next #(.N(N), .WIDTH(WIDTH)) u_next (
        .cur (prev),
        .nxt (exp_val)
    );

    // Extra bit keeps the range check correct when N == 2**WIDTH.
    assign in_range = ({1'b0, bus.cnt_in} < (WIDTH + 1)'(N));

    always_comb begin
        state_nx    = state;
        good_cnt_nx = good_cnt;
        wrap_nx     = 1'b0;
        err_nx      = 1'b0;
        good        = bus.cnt_valid && prev_ok && in_range && (bus.cnt_in == exp_val);
        if (bus.cnt_valid) begin
            case (state)
                ACQUIRE: begin
                    if (!good) begin
                        good_cnt_nx = '0;
                    end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                        state_nx    = LOCKED;
                        good_cnt_nx = '0;
                    end else begin
                        good_cnt_nx = good_cnt + GW'(1);
                    end
                end
                LOCKED: begin
                    if (good) begin
                        // good already implies cnt_in == 0 when prev is N-1
                        wrap_nx = (prev == WIDTH'(N - 1));
                    end else begin
                        err_nx      = 1'b1;
                        state_nx    = ACQUIRE;
                        good_cnt_nx = '0;
                    end
                end
                default: state_nx = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQUIRE;
            prev     <= '0;
            prev_ok  <= 1'b0;
            good_cnt <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            period_q <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_cnt_nx;
            wrap_q   <= wrap_nx;
            err_q    <= err_nx;
            if (bus.cnt_valid) begin
                prev    <= bus.cnt_in;
                prev_ok <= in_range;
            end
            if (wrap_nx && (period_q != '1)) begin
                period_q <= period_q + PERIOD_W'(1);
            end
            if (err_nx) begin
                sticky_q <= 1'b1;
            end else if (bus.err_clear) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.locked       = (state == LOCKED);
    assign bus.wrap_pulse   = wrap_q;
    assign bus.err_pulse    = err_q;
    assign bus.err_sticky   = sticky_q;
    assign bus.period_count = period_q;

endmodule

// File: tb/tb_mod_sequence_monitor.sv
// Bench for mod_sequence_monitor: reference-model scoreboard plus directed checks.
module tb_mod_sequence_monitor;

    typedef struct {
        bit locked;
        bit wrap;
        bit err;
        bit sticky;
        int per;
        int per2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt = '0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;

    int total = 0;
    int bad = 0;

    exp_t sb[$];
    exp_t mon_e;

    int m_prev = 0, m_ok = 0, m_good = 0, m_locked = 0;
    int m_per = 0, m_per2 = 0, m_sticky = 0;

    always #5 clk = ~clk;

    mod_sequence_monitor_if #(.WIDTH(4), .PERIOD_W(16)) bus1 ();
    mod_sequence_monitor_if #(.WIDTH(4), .PERIOD_W(2))  bus2 ();

    assign bus1.cnt_in    = cnt;
    assign bus1.cnt_valid = valid;
    assign bus1.err_clear = clr;
    assign bus2.cnt_in    = cnt;
    assign bus2.cnt_valid = valid;
    assign bus2.err_clear = clr;

    mod_sequence_monitor #(.N(8), .WIDTH(4), .LOCK_CNT(2), .PERIOD_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mod_sequence_monitor #(.N(8), .WIDTH(4), .LOCK_CNT(2), .PERIOD_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference model: one call per clock edge, result queued for the monitor.
    task automatic model(input int c, input bit v, input bit cl, input bit r);
        exp_t e;
        int   nxt;
        bit   g;
        e.wrap = 0;
        e.err  = 0;
        if (r) begin
            m_prev = 0; m_ok = 0; m_good = 0; m_locked = 0;
            m_per = 0; m_per2 = 0; m_sticky = 0;
        end else begin
            if (v) begin
                nxt = (m_prev == 7) ? 0 : m_prev + 1;
                g = (m_ok != 0) && (c < 8) && (c == nxt);
                if (m_locked == 0) begin
                    m_good = g ? m_good + 1 : 0;
                    if (m_good >= 2) begin
                        m_locked = 1;
                        m_good = 0;
                    end
                end else if (g) begin
                    if (m_prev == 7) begin
                        e.wrap = 1;
                        if (m_per < 65535) m_per++;
                        if (m_per2 < 3) m_per2++;
                    end
                end else begin
                    e.err = 1;
                    m_locked = 0;
                    m_good = 0;
                end
                m_prev = c;
                m_ok = (c < 8) ? 1 : 0;
            end
            if (e.err) m_sticky = 1;
            else if (cl) m_sticky = 0;
        end
        e.locked = (m_locked != 0);
        e.sticky = (m_sticky != 0);
        e.per    = m_per;
        e.per2   = m_per2;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if (bus1.locked !== mon_e.locked) begin
                bad++;
                $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, bus1.locked, mon_e.locked);
            end
            total++;
            if (bus1.wrap_pulse !== mon_e.wrap) begin
                bad++;
                $display("FAIL sb_wrap t=%0t got=%b exp=%b", $time, bus1.wrap_pulse, mon_e.wrap);
            end
            total++;
            if (bus1.err_pulse !== mon_e.err) begin
                bad++;
                $display("FAIL sb_err t=%0t got=%b exp=%b", $time, bus1.err_pulse, mon_e.err);
            end
            total++;
            if (bus1.err_sticky !== mon_e.sticky) begin
                bad++;
                $display("FAIL sb_sticky t=%0t got=%b exp=%b", $time, bus1.err_sticky, mon_e.sticky);
            end
            total++;
            if (bus1.period_count !== 16'(mon_e.per)) begin
                bad++;
                $display("FAIL sb_period t=%0t got=%0d exp=%0d", $time, bus1.period_count, mon_e.per);
            end
            total++;
            if (bus2.period_count !== 2'(mon_e.per2)) begin
                bad++;
                $display("FAIL sb_period_sat t=%0t got=%0d exp=%0d", $time, bus2.period_count, mon_e.per2);
            end
        end
    end

    task automatic drive(input int c, input bit v, input bit cl, input bit r);
        @(negedge clk);
        rst   = r;
        cnt   = 4'(c);
        valid = v;
        clr   = cl;
        model(c, v, cl, r);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input int c);
        drive(c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(5, 1'b1, 1'b0, 1'b1);
        drive(5, 1'b1, 1'b0, 1'b1);
        total++;
        if ({bus1.locked, bus1.wrap_pulse, bus1.err_pulse, bus1.err_sticky} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus1.locked, bus1.wrap_pulse, bus1.err_pulse, bus1.err_sticky});
        end
        total++;
        if (bus1.period_count !== 16'd0 || bus2.period_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_period got=%0d/%0d exp=0/0", bus1.period_count, bus2.period_count);
        end
    endtask

    task automatic test_lock_wrap();
        for (int i = 0; i < 25; i++) begin
            step(i % 8);
            if (i == 1) begin
                total++;
                if (bus1.locked !== 1'b0) begin
                    bad++;
                    $display("FAIL early_lock got=%b exp=0", bus1.locked);
                end
            end
            if (i == 2) begin
                total++;
                if (bus1.locked !== 1'b1) begin
                    bad++;
                    $display("FAIL lock_after_2 got=%b exp=1", bus1.locked);
                end
            end
            if (i == 8) begin
                total++;
                if (bus1.wrap_pulse !== 1'b1 || bus1.period_count !== 16'd1) begin
                    bad++;
                    $display("FAIL first_wrap got=%b/%0d exp=1/1", bus1.wrap_pulse, bus1.period_count);
                end
            end
            if (i == 24) begin
                total++;
                if (bus1.period_count !== 16'd3) begin
                    bad++;
                    $display("FAIL third_wrap got=%0d exp=3", bus1.period_count);
                end
            end
        end
    endtask

    task automatic test_mismatch();
        step(1); step(2); step(3); step(5);
        total++;
        if ({bus1.err_pulse, bus1.err_sticky, bus1.locked} !== 3'b110) begin
            bad++;
            $display("FAIL mismatch_err got=%b exp=110", {bus1.err_pulse, bus1.err_sticky, bus1.locked});
        end
        step(6);
        total++;
        if ({bus1.err_pulse, bus1.locked} !== 2'b00) begin
            bad++;
            $display("FAIL mismatch_pulse_len got=%b exp=00", {bus1.err_pulse, bus1.locked});
        end
        step(7);
        total++;
        if (bus1.locked !== 1'b1) begin
            bad++;
            $display("FAIL mismatch_relock got=%b exp=1", bus1.locked);
        end
        step(0);
    endtask

    task automatic test_out_of_range();
        step(1); step(2); step(3); step(9);
        total++;
        if ({bus1.err_pulse, bus1.locked} !== 2'b10) begin
            bad++;
            $display("FAIL oor_err got=%b exp=10", {bus1.err_pulse, bus1.locked});
        end
        step(0); step(1);
        total++;
        if (bus1.locked !== 1'b0) begin
            bad++;
            $display("FAIL oor_prev_ok got=%b exp=0", bus1.locked);
        end
        step(2);
        total++;
        if (bus1.locked !== 1'b1) begin
            bad++;
            $display("FAIL oor_relock got=%b exp=1", bus1.locked);
        end
        for (int v = 3; v < 8; v++) step(v);
        step(0);
    endtask

    task automatic test_valid_gap();
        step(1); step(2);
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b0, 1'b0, 1'b0);
            total++;
            if ({bus1.err_pulse, bus1.locked} !== 2'b01) begin
                bad++;
                $display("FAIL gap_hold got=%b exp=01", {bus1.err_pulse, bus1.locked});
            end
        end
        step(3);
        total++;
        if ({bus1.err_pulse, bus1.locked} !== 2'b01) begin
            bad++;
            $display("FAIL gap_resume got=%b exp=01", {bus1.err_pulse, bus1.locked});
        end
        step(4);
    endtask

    task automatic test_err_clear();
        drive(6, 1'b1, 1'b1, 1'b0);
        total++;
        if ({bus1.err_pulse, bus1.err_sticky} !== 2'b11) begin
            bad++;
            $display("FAIL clear_vs_set got=%b exp=11", {bus1.err_pulse, bus1.err_sticky});
        end
        step(7);
        drive(0, 1'b1, 1'b1, 1'b0);
        total++;
        if (bus1.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL clear_alone got=%b exp=0", bus1.err_sticky);
        end
        total++;
        if ({bus1.locked, bus1.wrap_pulse} !== 2'b10) begin
            bad++;
            $display("FAIL lock_wrap_uncounted got=%b exp=10", {bus1.locked, bus1.wrap_pulse});
        end
    endtask

    task automatic test_saturation();
        drive(0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 41; i++) step(i % 8);
        total++;
        if (bus2.period_count !== 2'd3) begin
            bad++;
            $display("FAIL period_saturate got=%0d exp=3", bus2.period_count);
        end
        total++;
        if (bus1.period_count !== 16'd5) begin
            bad++;
            $display("FAIL period_five got=%0d exp=5", bus1.period_count);
        end
    endtask

    task automatic test_reset_mid();
        step(1); step(2);
        drive(3, 1'b1, 1'b0, 1'b1);
        total++;
        if ({bus1.locked, bus1.wrap_pulse, bus1.err_pulse, bus1.err_sticky} !== 4'b0000 ||
            bus1.period_count !== 16'd0 || bus2.period_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid got=%b/%0d exp=0000/0",
                     {bus1.locked, bus1.wrap_pulse, bus1.err_pulse, bus1.err_sticky}, bus1.period_count);
        end
        step(4); step(5);
        total++;
        if (bus1.locked !== 1'b0) begin
            bad++;
            $display("FAIL first_sample_not_good got=%b exp=0", bus1.locked);
        end
        step(6);
        total++;
        if (bus1.locked !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_lock got=%b exp=1", bus1.locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock_wrap();
        test_mismatch();
        test_out_of_range();
        test_valid_gap();
        test_err_clear();
        test_saturation();
        test_reset_mid();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
